proc_core: RTL and testbench



---
 rtl/proc_core.sv | 162 ++++++++++++++++
 tb/tb_proc_core.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_core.sv
// proc_core: single-cycle 32-bit MIPS-subset core with loadable instruction
// memory, asynchronous-read data memory, 32x32 register file and ALU.
// Optional feature: define PROC_MUL_EN to enable R-type MUL (funct 0x18).
module proc_core #(
   parameter int IMEM_AW = 8,
   parameter int DMEM_AW = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [31:0]        startPC,
   input  logic               imem_we,
   input  logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_wdata,
   output logic [31:0]        pc,
   output logic               halted,
   output logic               wb_en,
   output logic [4:0]         wb_addr,
   output logic [31:0]        wb_data
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
`ifdef PROC_MUL_EN
   localparam logic [5:0] FN_MUL   = 6'h18;
`endif

   logic [31:0] imem_q [0:(1<<IMEM_AW)-1];
   logic [31:0] dmem_q [0:(1<<DMEM_AW)-1];
   logic [31:0] rf_q   [0:31];

   logic [31:0] pc_q, pc_d;
   logic        halted_q, halted_d;

   logic [31:0] instr;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [25:0] target;
   logic [31:0] rs_val, rt_val, imm_sext, pc_plus4, addr_sum;

   logic        wr_raw, st_raw, halt_hit;
   logic [4:0]  dst;
   logic [31:0] res, pc_nxt;
   logic        active, rf_we, dmem_we;

   // Instruction fetch and field extraction; pc[1:0] is ignored.
   assign instr    = imem_q[pc_q[IMEM_AW+1:2]];
   assign op       = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign funct    = instr[5:0];
   assign target   = instr[25:0];
   assign imm_sext = {{16{instr[15]}}, instr[15:0]};

   // R0 is hard-wired to zero on the read side, so rf_q[0] is never trusted.
   assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
   assign pc_plus4 = pc_q + 32'd4;
   assign addr_sum = rs_val + imm_sext;

   // Decode/execute: raw intent of the instruction, before reset/halt gating.
   always_comb begin
      wr_raw   = 1'b0;
      st_raw   = 1'b0;
      halt_hit = 1'b0;
      dst      = rd;
      res      = '0;
      pc_nxt   = pc_plus4;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD: begin wr_raw = 1'b1; res = rs_val + rt_val; end
               FN_SUB: begin wr_raw = 1'b1; res = rs_val - rt_val; end
               FN_AND: begin wr_raw = 1'b1; res = rs_val & rt_val; end
               FN_OR:  begin wr_raw = 1'b1; res = rs_val | rt_val; end
               FN_SLT: begin
                  wr_raw = 1'b1;
                  res    = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
               end
`ifdef PROC_MUL_EN
               FN_MUL: begin wr_raw = 1'b1; res = rs_val * rt_val; end
`endif
               default: ;
            endcase
         end
         OP_ADDI: begin wr_raw = 1'b1; dst = rt; res = addr_sum; end
         OP_LW: begin
            wr_raw = 1'b1;
            dst    = rt;
            res    = dmem_q[addr_sum[DMEM_AW+1:2]];
         end
         OP_SW:   st_raw = 1'b1;
         OP_BEQ: begin
            if (rs_val == rt_val) pc_nxt = pc_plus4 + {imm_sext[29:0], 2'b00};
         end
         OP_J:    pc_nxt = {pc_plus4[31:28], target, 2'b00};
         OP_HALT: halt_hit = 1'b1;
         default: ;
      endcase
   end

   // Nothing retires while in reset or after HALT; HALT itself holds pc.
   assign active  = !RESET && !halted_q;
   assign rf_we   = active && wr_raw && (dst != 5'd0);
   assign dmem_we = active && st_raw;

   // Next-state for pc and halt flag.
   always_comb begin
      pc_d     = pc_q;
      halted_d = halted_q;
      if (RESET) begin
         pc_d     = startPC;
         halted_d = 1'b0;
      end else if (active) begin
         if (halt_hit) halted_d = 1'b1;
         else          pc_d     = pc_nxt;
      end
   end

   // pc / halted state register.
   always_ff @(posedge CLK) begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
   end

   // Register file: cleared by reset, written at the edge.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (rf_we) begin
         rf_q[dst] <= res;
      end
   end

   // Data memory store port; contents survive reset.
   always_ff @(posedge CLK) begin
      if (dmem_we) dmem_q[addr_sum[DMEM_AW+1:2]] <= rt_val;
   end

   // Instruction memory load port, usable in any state.
   always_ff @(posedge CLK) begin
      if (imem_we) imem_q[imem_addr] <= imem_wdata;
   end

   assign pc      = pc_q;
   assign halted  = halted_q;
   assign wb_en   = rf_we;
   assign wb_addr = dst;
   assign wb_data = res;

endmodule

// File: tb/tb_proc_core.sv
// Self-checking bench for proc_core: directed table/sequences plus random
// programs checked against an instruction-level reference model.
module tb_proc_core;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] startPC = 32'h0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_addr = 8'h0;
  logic [31:0] imem_wdata = 32'h0;
  logic [31:0] pc;
  logic        halted, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  proc_core #(.IMEM_AW(8), .DMEM_AW(8)) dut (
    .CLK(CLK), .RESET(RESET), .startPC(startPC),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pc(pc), .halted(halted), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t alu_tab [7];

  // reference model state
  logic [31:0] mimem [256];
  logic [31:0] mdmem [256];
  logic [31:0] mregs [32];
  logic [31:0] mpc;
  logic        mhalt;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] R(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {OP_R, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] I(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] Jt(logic [25:0] t);
    return {OP_J, t};
  endfunction

  task automatic wr_imem(input logic [7:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_addr = a; imem_wdata = d;
    mimem[a] = d;
    step();
    imem_we = 1'b0;
  endtask

  // hold reset two edges, check reset state, release
  task automatic do_reset(input logic [31:0] s);
    RESET = 1'b1; startPC = s;
    step(); step();
    chk("rst_pc", pc, s);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    RESET = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] rv;
    logic [4:0]  a, b, c;
    logic [5:0]  fn;
    int          k, off;
    rv = $urandom;
    a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
    k = int'($urandom_range(0, 99));
    if (k < 30) begin
      case ($urandom_range(0, 6))
        0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
        4: fn = 6'h2A; 5: fn = 6'h18; default: fn = rv[5:0];
      endcase
      return R(a, b, c, fn);
    end
    if (k < 50) return I(OP_ADDI, a, b, rv[15:0]);
    if (k < 60) return I(OP_LW, a, b, rv[15:0]);
    if (k < 70) return I(OP_SW, a, b, rv[15:0]);
    if (k < 80) begin
      off = int'($urandom_range(0, 15)) - 8;
      return I(OP_BEQ, a, b, off[15:0]);
    end
    if (k < 86) return Jt(rv[25:0]);
    if (k < 88) return {OP_HALT, rv[25:0]};
    return rv;
  endfunction

  // Reference model: execute one instruction per cycle at the ISA level,
  // comparing the DUT's visible state before each edge.
  task automatic run_model(input int ncyc);
    logic [31:0] ins, a, b, se, npc, ed, ea;
    logic [4:0]  dst;
    logic        wr, st, nh;
    for (int c = 0; c < ncyc; c++) begin
      ins = mimem[mpc[9:2]];
      a   = mregs[ins[25:21]];
      b   = mregs[ins[20:16]];
      se  = {{16{ins[15]}}, ins[15:0]};
      ea  = a + se;
      npc = mpc + 32'd4;
      wr = 1'b0; st = 1'b0; nh = mhalt; dst = ins[15:11]; ed = 32'd0;
      if (mhalt) npc = mpc;
      else case (ins[31:26])
        OP_R: case (ins[5:0])
          6'h20: begin wr = 1'b1; ed = a + b; end
          6'h22: begin wr = 1'b1; ed = a - b; end
          6'h24: begin wr = 1'b1; ed = a & b; end
          6'h25: begin wr = 1'b1; ed = a | b; end
          6'h2A: begin wr = 1'b1; ed = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
`ifdef PROC_MUL_EN
          6'h18: begin wr = 1'b1; ed = a * b; end
`endif
          default: ;
        endcase
        OP_ADDI: begin wr = 1'b1; dst = ins[20:16]; ed = ea; end
        OP_LW:   begin wr = 1'b1; dst = ins[20:16]; ed = mdmem[ea[9:2]]; end
        OP_SW:   st = 1'b1;
        OP_BEQ:  if (a == b) npc = mpc + 32'd4 + (se << 2);
        OP_J:    npc = {npc[31:28], ins[25:0], 2'b00};
        OP_HALT: begin nh = 1'b1; npc = mpc; end
        default: ;
      endcase
      if (dst == 5'd0) wr = 1'b0;
      chk("rnd_pc", pc, mpc);
      chk("rnd_halted", 32'(halted), 32'(mhalt));
      chk("rnd_wb_en", 32'(wb_en), 32'(wr));
      if (wr) begin
        chk("rnd_wb_addr", 32'(wb_addr), 32'(dst));
        chk("rnd_wb_data", wb_data, ed);
        mregs[dst] = ed;
      end
      if (st) mdmem[ea[9:2]] = b;
      mpc = npc; mhalt = nh;
      step();
    end
  endtask

  initial begin
    logic [31:0] rv;
    // ---------------- table: ALU sequence at 0x10 ----------------
    alu_tab[0] = '{I(OP_ADDI, 0, 1, 16'd5),      32'h10, 1'b1, 5'd1, 32'd5};
    alu_tab[1] = '{I(OP_ADDI, 0, 2, 16'hFFFD),   32'h14, 1'b1, 5'd2, 32'hFFFFFFFD};
    alu_tab[2] = '{R(1, 2, 3, 6'h20),            32'h18, 1'b1, 5'd3, 32'd2};
    alu_tab[3] = '{R(2, 1, 4, 6'h22),            32'h1C, 1'b1, 5'd4, 32'hFFFFFFF8};
    alu_tab[4] = '{R(2, 1, 5, 6'h2A),            32'h20, 1'b1, 5'd5, 32'd1};
    alu_tab[5] = '{I(OP_ADDI, 0, 0, 16'd7),      32'h24, 1'b0, 5'd0, 32'd0};
    alu_tab[6] = '{{OP_HALT, 26'd0},             32'h28, 1'b0, 5'd0, 32'd0};

    // load every directed program while reset is held
    RESET = 1'b1; startPC = 32'h10;
    for (int i = 0; i < 7; i++) wr_imem(8'(4 + i), alu_tab[i].instr);
    // memory @0x100
    wr_imem(64, I(OP_ADDI, 0, 1, 16'h1234));
    wr_imem(65, I(OP_SW, 0, 1, 16'd8));
    wr_imem(66, I(OP_LW, 0, 6, 16'd8));
    wr_imem(67, I(OP_ADDI, 0, 0, 16'd7));
    wr_imem(68, {OP_HALT, 26'd0});
    // control @0x200
    wr_imem(128, I(OP_ADDI, 0, 1, 16'd1));
    wr_imem(129, I(OP_BEQ, 1, 0, 16'd5));
    wr_imem(130, I(OP_BEQ, 0, 0, 16'd2));
    wr_imem(131, I(OP_ADDI, 0, 7, 16'd99));
    wr_imem(132, I(OP_ADDI, 0, 7, 16'd99));
    wr_imem(133, Jt(26'h40));
    // loop @0x280, post-reset probe @0x2A0
    wr_imem(160, I(OP_ADDI, 2, 2, 16'd1));
    wr_imem(161, Jt(26'hA0));
    wr_imem(168, R(2, 1, 8, 6'h20));
    wr_imem(169, I(OP_LW, 0, 9, 16'd8));
    wr_imem(170, {OP_HALT, 26'd0});
    // mul @0x2C0
    wr_imem(176, I(OP_ADDI, 0, 1, 16'd7));
    wr_imem(177, I(OP_ADDI, 0, 2, 16'd6));
    wr_imem(178, R(1, 2, 10, 6'h18));
    wr_imem(179, R(10, 0, 11, 6'h20));
    wr_imem(180, {OP_HALT, 26'd0});
    // dmem clear loop @0x300
    wr_imem(192, I(OP_ADDI, 0, 2, 16'h0400));
    wr_imem(193, I(OP_SW, 1, 0, 16'd0));
    wr_imem(194, I(OP_ADDI, 1, 1, 16'd4));
    wr_imem(195, I(OP_BEQ, 1, 2, 16'd1));
    wr_imem(196, Jt(26'hC1));
    wr_imem(197, {OP_HALT, 26'd0});

    // ---------------- reset/start + ALU table ----------------
    do_reset(32'h10);
    for (int i = 0; i < 7; i++) begin
      chk("alu_pc", pc, alu_tab[i].pc);
      chk("alu_wb_en", 32'(wb_en), 32'(alu_tab[i].en));
      if (alu_tab[i].en) begin
        chk("alu_wb_addr", 32'(wb_addr), 32'(alu_tab[i].addr));
        chk("alu_wb_data", wb_data, alu_tab[i].data);
      end
      step();
    end
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", pc, 32'h28);
    step(); step();
    chk("halt_pc_frozen", pc, 32'h28);
    chk("halt_no_wb", 32'(wb_en), 32'd0);

    // ---------------- memory ----------------
    do_reset(32'h100);
    chk("mem_addi", wb_data, 32'h1234);
    step();
    chk("mem_sw_no_wb", 32'(wb_en), 32'd0);
    step();
    chk("mem_lw_en", 32'(wb_en), 32'd1);
    chk("mem_lw_addr", 32'(wb_addr), 32'd6);
    chk("mem_lw_data", wb_data, 32'h1234);
    step();
    chk("mem_r0_no_wb", 32'(wb_en), 32'd0);

    // ---------------- control ----------------
    do_reset(32'h200);
    step();
    chk("beq_nt_at", pc, 32'h204);
    step();
    chk("beq_nt_pc", pc, 32'h208);
    step();
    chk("beq_t_pc", pc, 32'h214);
    step();
    chk("j_pc", pc, 32'h100);
    chk("j_fetch", wb_data, 32'h1234);

    // ---------------- reset mid-run ----------------
    do_reset(32'h280);
    for (int k = 1; k <= 4; k++) begin
      chk("loop_data", wb_data, 32'(k));
      step(); step();
    end
    RESET = 1'b1; startPC = 32'h2A0;
    step();
    chk("midrst_pc", pc, 32'h2A0);
    chk("midrst_wb_en", 32'(wb_en), 32'd0);
    RESET = 1'b0; #1;
    chk("midrst_reg_en", 32'(wb_en), 32'd1);
    chk("midrst_reg_zero", wb_data, 32'd0);
    step();
    chk("midrst_dmem_keep", wb_data, 32'h1234);

    // ---------------- MUL option ----------------
    do_reset(32'h2C0);
    step(); step();
`ifdef PROC_MUL_EN
    chk("mul_en", 32'(wb_en), 32'd1);
    chk("mul_data", wb_data, 32'd42);
    step();
    chk("mul_use", wb_data, 32'd42);
`else
    chk("mul_nop_en", 32'(wb_en), 32'd0);
    step();
    chk("mul_nop_dst", wb_data, 32'd0);
`endif

    // ---------------- clear dmem, then random programs ----------------
    do_reset(32'h300);
    for (int c = 0; c < 3000 && !halted; c++) step();
    chk("clr_halted", 32'(halted), 32'd1);
    chk("clr_pc", pc, 32'h314);
    for (int i = 0; i < 256; i++) mdmem[i] = 32'd0;

    for (int run = 0; run < 3; run++) begin
      RESET = 1'b1;
      for (int i = 0; i < 256; i++) wr_imem(8'(i), rand_instr());
      rv = $urandom;
      do_reset(rv);
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mpc = rv; mhalt = 1'b0;
      run_model(300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
